flopr_pipe: RTL and testbench
=============================

# flopr_pipe

Parametrised elastic pipeline register: a chain of DEPTH stages of WIDTH-bit resettable flip-flops with per-stage valid bits, a ready/valid handshake on both sides, bubble collapse and a synchronous flush. It is the next generation of the fixed 32-bit resettable register. It sits between pipeline stages of the CDA3102 datapath, for example IF/ID and ID/EX, wherever a stall or squash must be absorbed without losing data.

## Interface
- WIDTH, 32, data bits per stage (≥1)
- DEPTH, 2, number of register stages (≥1)
- CW, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; all state cleared while low
- D  input  WIDTH  upstream data
- in_valid  input  1  D holds a valid item
- in_ready  output  1  pipe accepts D this cycle
- Q  output  WIDTH  output data; forced to 0 when out_valid=0
- out_valid  output  1  Q holds a valid item
- out_ready  input  1  downstream accepts Q this cycle
- flush  input  1  synchronous squash of all contents
- count  output  CW  number of valid stages (only with FLOPR_PIPE_COUNT_EN)

## Operation
- Stage 0 is the input side; stage DEPTH-1 drives Q/out_valid.
- Each stage k holds a valid bit v[k] and data d[k].
- Ready chain (combinational):
  - r[DEPTH-1] = ~v[DEPTH-1] | out_ready
  - r[k] = ~v[k] | r[k+1]
  - in_ready = r[0]
- On a rising clk, a stage with r[k]=1 loads from upstream: v[k] ← upstream valid (v[k-1], or in_valid for k=0).
  - d[k] ← upstream data only when upstream valid=1; otherwise d[k] holds.
- A stage with r[k]=0 holds both v[k] and d[k] (stall).
- Bubble collapse: an empty stage accepts upstream data even when downstream is stalled.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Flush is synchronous and overrides all loads: the next edge sets every v[k]=0 and every d[k]=0.
  - An input offered in the flush cycle is discarded.
  - in_ready is unaffected by flush in the same cycle.
- Data is never duplicated, dropped (except by flush or reset) or reordered.

## Timing
- Reset (reset=0, asynchronous): v=0, d=0, Q=0, out_valid=0, in_ready=1, count=0. Release is synchronous to the next clk edge.
- Latency: an item accepted at edge t appears on Q after edge t+DEPTH-1 when no stalls occur, giving a DEPTH-cycle pipe. With DEPTH=1 the item is visible right after the accepting edge.
- Throughput: one item per cycle while out_ready=1.
- Full (all v=1, out_ready=0): in_ready=0 and all stages hold.
- Full with out_ready=1: simultaneous accept and emit, and occupancy is unchanged.
- Empty: out_valid=0 and Q=0 regardless of stale d[DEPTH-1].
- Reset asserted mid-transfer: contents are lost immediately and no item appears after release.
- flush and reset both active: reset wins.
- The bench uses a 20-unit clock period with stimulus changing away from rising edges.

## Configuration
- FLOPR_PIPE_COUNT_EN defined: the count port exists and equals the number of v[k]=1 after each edge. It is held in a registered counter:
  - +1 on input transfer only
  - −1 on output transfer only
  - unchanged on both or neither
  - 0 on flush or reset
- FLOPR_PIPE_COUNT_EN undefined: the count port and counter are absent, and behaviour is otherwise identical.

## Structure
- Package flopr_pipe_pkg: FLOPR_PIPE_WIDTH_DEFAULT=32, FLOPR_PIPE_DEPTH_DEFAULT=2, and a function computing CW from DEPTH.
- Sub-module flopr_stage: one stage (valid bit, WIDTH-bit data, load/flush/async reset), instantiated DEPTH times in a generate loop.
- The ready chain, Q masking and the optional counter live in flopr_pipe.

## Test plan
- Reset: hold reset=0 with D=52, in_valid=1 → Q=0, out_valid=0, in_ready=1, count=0.
- Streaming (DEPTH=2): send 52, 53, 54 on consecutive cycles with out_ready=1 → Q=52 after the 2nd edge, then 53 and 54 on successive edges.
- Backpressure: out_ready=0 while sending 1, 2, 3 → after two edges, out_valid=1, Q=1, in_ready=0, count=2; item 3 is held upstream. Raising out_ready drains 1 then 2 in order with no loss.
- Bubble collapse: stage DEPTH-1 holds 7 stalled and stage 0 is empty; send 8 → accepted (in_ready=1), count=2, Q stays 7.
- Flush: pipe holds 5, 6; assert flush for one cycle with in_valid=1, D=9 → out_valid=0, Q=0, count=0 next cycle, and 9 never appears.
- Async reset mid-stream: pull reset low between edges while full → Q=0 and out_valid=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/flopr_pipe_pkg.sv
// Shared constants and helpers for the flopr_pipe elastic pipeline register.
//   FLOPR_PIPE_WIDTH_DEFAULT : default data bits per stage
//   FLOPR_PIPE_DEPTH_DEFAULT : default number of register stages
//   cnt_width(depth)         : bits needed to hold an occupancy of 0..depth
package flopr_pipe_pkg;

  localparam int unsigned FLOPR_PIPE_WIDTH_DEFAULT = 32;
  localparam int unsigned FLOPR_PIPE_DEPTH_DEFAULT = 2;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flopr_stage.sv
// One stage of the elastic pipe: a valid bit plus a Width-bit data register.
// Ports:
//   clk_i   : rising-edge clock
//   rst_ni  : asynchronous active-low reset, clears valid and data
//   load_i  : stage is ready and takes the upstream slot this edge
//   flush_i : synchronous clear of valid and data, overrides load_i
//   valid_i : upstream valid
//   data_i  : upstream data
//   valid_o : stage valid bit
//   data_o  : stage data (raw, not masked by valid)
module flopr_stage
  import flopr_pipe_pkg::*;
#(
  parameter int unsigned Width = FLOPR_PIPE_WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = valid_i;
      // A bubble moving in leaves the old data in place.
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/flopr_pipe.sv
// Elastic pipeline register: DEPTH stages of WIDTH-bit flops with per-stage
// valid bits, ready/valid handshake on both sides, bubble collapse and a
// synchronous flush. Stage 0 faces the input, stage DEPTH-1 drives Q.
// Optional feature macro: FLOPR_PIPE_COUNT_EN adds the registered occupancy
// port count.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset, clears all stages
//   D         : upstream data
//   in_valid  : D holds a valid item
//   in_ready  : pipe accepts D this cycle
//   Q         : output data, zero when out_valid is low
//   out_valid : Q holds a valid item
//   out_ready : downstream accepts Q this cycle
//   flush     : synchronous squash of all contents
//   count     : number of valid stages (FLOPR_PIPE_COUNT_EN only)
module flopr_pipe
  import flopr_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = FLOPR_PIPE_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = FLOPR_PIPE_DEPTH_DEFAULT
`ifdef FLOPR_PIPE_COUNT_EN
  ,
  localparam int unsigned CW = cnt_width(DEPTH)
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Q,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush
`ifdef FLOPR_PIPE_COUNT_EN
  ,
  output logic [CW-1:0]    count
`endif
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] d       [DEPTH];
  logic [WIDTH-1:0] up_data [DEPTH];

  // Ready ripples from the output back: a stage can load if it is empty or
  // the stage after it can load too.
  always_comb begin : ready_chain
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      r      = ~v[k] | r;
      rdy[k] = r;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign up_valid[k] = in_valid;
      assign up_data[k]  = D;
    end else begin : g_link
      assign up_valid[k] = v[k-1];
      assign up_data[k]  = d[k-1];
    end

    flopr_stage #(
      .Width(WIDTH)
    ) u_stage (
      .clk_i  (clk),
      .rst_ni (reset),
      .load_i (rdy[k]),
      .flush_i(flush),
      .valid_i(up_valid[k]),
      .data_i (up_data[k]),
      .valid_o(v[k]),
      .data_o (d[k])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[DEPTH-1];
  assign Q         = out_valid ? d[DEPTH-1] : '0;

`ifdef FLOPR_PIPE_COUNT_EN
  logic          in_xfer, out_xfer;
  logic [CW-1:0] count_q, count_d;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (in_xfer && !out_xfer) begin
      count_d = count_q + CW'(1);
    end else if (out_xfer && !in_xfer) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
`endif

endmodule

// File: tb/tb_flopr_pipe.sv
module tb_flopr_pipe;

  localparam int unsigned W = 32;
  localparam int unsigned N = 2;

  logic         clk;
  logic         reset;
  logic [W-1:0] D;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Q;
  logic         out_valid;
  logic         out_ready;
  logic         flush;
`ifdef FLOPR_PIPE_COUNT_EN
  logic [1:0]   count;
`endif

  int total;
  int bad;

  flopr_pipe #(
    .WIDTH(W),
    .DEPTH(N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .D        (D),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Q        (Q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .flush    (flush)
`ifdef FLOPR_PIPE_COUNT_EN
    ,
    .count    (count)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance to 5 units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #5;
  endtask

  task automatic test_reset();
    reset = 1'b0; D = 32'd52; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    #25;
    total++; if (Q !== 32'd0) begin bad++; $display("FAIL reset_q got=%0d exp=0", Q); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_ov got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ir got=%b exp=1", in_ready); end
`ifdef FLOPR_PIPE_COUNT_EN
    total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", count); end
`endif
    in_valid = 1'b0;
    #2 reset = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rel_ov got=%b exp=0", out_valid); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1; in_valid = 1'b1; D = 32'd52;
    step(); D = 32'd53;
    step();
    total++; if (Q !== 32'd52 || out_valid !== 1'b1) begin
      bad++; $display("FAIL stream_0 got=%0d/%b exp=52/1", Q, out_valid); end
    D = 32'd54;
    step();
    total++; if (Q !== 32'd53) begin bad++; $display("FAIL stream_1 got=%0d exp=53", Q); end
    in_valid = 1'b0;
    step();
    total++; if (Q !== 32'd54) begin bad++; $display("FAIL stream_2 got=%0d exp=54", Q); end
    step();
    total++; if (Q !== 32'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL stream_empty got=%0d/%b exp=0/0", Q, out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; D = 32'd1;
    step(); D = 32'd2;
    step(); D = 32'd3;
    #1;
    total++; if (out_valid !== 1'b1 || Q !== 32'd1) begin
      bad++; $display("FAIL bp_full got=%0d/%b exp=1/1", Q, out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ir got=%b exp=0", in_ready); end
`ifdef FLOPR_PIPE_COUNT_EN
    total++; if (count !== 2'd2) begin bad++; $display("FAIL bp_cnt got=%0d exp=2", count); end
`endif
    step();
    total++; if (Q !== 32'd1) begin bad++; $display("FAIL bp_hold got=%0d exp=1", Q); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ir_up got=%b exp=1", in_ready); end
    step(); in_valid = 1'b0;
    total++; if (Q !== 32'd2) begin bad++; $display("FAIL bp_drain2 got=%0d exp=2", Q); end
`ifdef FLOPR_PIPE_COUNT_EN
    total++; if (count !== 2'd2) begin bad++; $display("FAIL bp_cnt_both got=%0d exp=2", count); end
`endif
    step();
    total++; if (Q !== 32'd3) begin bad++; $display("FAIL bp_drain3 got=%0d exp=3", Q); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
`ifdef FLOPR_PIPE_COUNT_EN
    total++; if (count !== 2'd0) begin bad++; $display("FAIL bp_cnt_end got=%0d exp=0", count); end
`endif
  endtask

  task automatic test_bubble();
    out_ready = 1'b0; in_valid = 1'b1; D = 32'd7;
    step(); in_valid = 1'b0;
    step();
    // Stage 1 holds 7 stalled, stage 0 is a bubble.
    in_valid = 1'b1; D = 32'd8;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bub_ir got=%b exp=1", in_ready); end
    step(); in_valid = 1'b0;
    total++; if (Q !== 32'd7) begin bad++; $display("FAIL bub_q got=%0d exp=7", Q); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bub_full got=%b exp=0", in_ready); end
`ifdef FLOPR_PIPE_COUNT_EN
    total++; if (count !== 2'd2) begin bad++; $display("FAIL bub_cnt got=%0d exp=2", count); end
`endif
    out_ready = 1'b1;
    step();
    total++; if (Q !== 32'd8) begin bad++; $display("FAIL bub_next got=%0d exp=8", Q); end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; D = 32'd5;
    step(); D = 32'd6;
    step();
    // Downstream ready during flush, so without the override 9 would load.
    flush = 1'b1; D = 32'd9; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_ir got=%b exp=1", in_ready); end
    step(); flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || Q !== 32'd0) begin
      bad++; $display("FAIL fl_clear got=%0d/%b exp=0/0", Q, out_valid); end
`ifdef FLOPR_PIPE_COUNT_EN
    total++; if (count !== 2'd0) begin bad++; $display("FAIL fl_cnt got=%0d exp=0", count); end
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_valid !== 1'b0) begin
        bad++; $display("FAIL fl_ghost%0d got=%0d/%b exp=0/0", i, Q, out_valid); end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; D = 32'd11;
    step(); D = 32'd12;
    step(); in_valid = 1'b0;
    total++; if (Q !== 32'd11) begin bad++; $display("FAIL ar_pre got=%0d exp=11", Q); end
    reset = 1'b0;
    #2;
    total++; if (Q !== 32'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL ar_now got=%0d/%b exp=0/0", Q, out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ar_ir got=%b exp=1", in_ready); end
`ifdef FLOPR_PIPE_COUNT_EN
    total++; if (count !== 2'd0) begin bad++; $display("FAIL ar_cnt got=%0d exp=0", count); end
`endif
    step();
    reset = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_valid !== 1'b0) begin
        bad++; $display("FAIL ar_ghost%0d got=%0d/%b exp=0/0", i, Q, out_valid); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
